clk_ratio_meter: RTL and testbench

Measures a divided clock against its source clock. The block samples a slow divided signal on `clk_in`, counts its high time, low time and period in `clk_in` cycles, and reports each completed period. It also flags lock after a run of identical periods and flags a stuck or too-slow input. It sits beside the odd/even clock dividers as their in-system checker: the divider produces `clk_out`, and this block consumes it.

---
 rtl/clk_meas_pkg.sv | 15 +
 rtl/edge_sync.sv | 35 +++
 rtl/clk_ratio_meter.sv | 171 +++++++++++++++++
 tb/tb_clk_ratio_meter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and default sizing for the divided-clock ratio meter.
package clk_meas_pkg;

  localparam int MAX_DIV_DEF   = 255;
  localparam int LOCK_N_DEF    = 4;
  localparam int CNT_WIDTH_DEF = $clog2(MAX_DIV_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } meas_state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level, plus an edge flop that
// yields registered one-cycle rise/fall strobes aligned with the level.
module edge_sync (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q, sync3_q;
  logic rise_q, fall_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise_q  <= sync2_q & ~sync3_q;
      fall_q  <= ~sync2_q & sync3_q;
    end
  end

  assign level = sync3_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures high/low/period of a divided clock in clk_in cycles, with lock
// detection over repeated equal periods and a stuck-input timeout.
//   state   | meaning
//   IDLE    | disabled, counters cleared
//   SYNC    | waiting for first rise, partial period discarded
//   HIGH    | counting high phase
//   LOW     | counting low phase, rise completes a measurement
module clk_ratio_meter
  import clk_meas_pkg::*;
#(
  parameter int MAX_DIV   = MAX_DIV_DEF,
  parameter int LOCK_N    = LOCK_N_DEF,
  parameter int CNT_WIDTH = $clog2(MAX_DIV + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic [CNT_WIDTH-1:0] low_time,
  output logic [CNT_WIDTH:0]   period,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_DIV);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [3:0]           MATCH_TOP = 4'(LOCK_N - 1);

  logic rise, fall;

  meas_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [CNT_WIDTH-1:0] high_q, high_d, low_q, low_d;
  logic [CNT_WIDTH:0]   period_q, period_d, prev_q, prev_d;
  logic [CNT_WIDTH:0]   sum;
  logic [3:0]           match_q, match_d;
  logic                 first_q, first_d;
  logic                 valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;
  logic                 to_evt;

  edge_sync u_edge_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .level  (),
    .rise   (rise),
    .fall   (fall)
  );

  assign sum = {1'b0, hcnt_q} + {1'b0, lcnt_q};

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    high_d    = high_q;
    low_d     = low_q;
    period_d  = period_q;
    prev_d    = prev_q;
    match_d   = match_q;
    first_d   = first_q;
    locked_d  = locked_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    to_evt    = 1'b0;

    if (!en) begin
      state_d  = ST_IDLE;
      hcnt_d   = '0;
      lcnt_d   = '0;
      first_d  = 1'b1;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          hcnt_d  = '0;
          lcnt_d  = '0;
          first_d = 1'b1;
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (rise) begin
            state_d = ST_HIGH;
            hcnt_d  = CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state_d = ST_LOW;
            lcnt_d  = CNT_ONE;
          end else if (hcnt_q == CNT_MAX) begin
            to_evt = 1'b1;
          end else begin
            hcnt_d = hcnt_q + CNT_ONE;
          end
        end
        ST_LOW: begin
          if (rise) begin
            high_d   = hcnt_q;
            low_d    = lcnt_q;
            period_d = sum;
            valid_d  = 1'b1;
            state_d  = ST_HIGH;
            hcnt_d   = CNT_ONE;
            prev_d   = sum;
            first_d  = 1'b0;
            // The first period after (re)sync never counts as a repeat.
            if (!first_q && (sum == prev_q))
              match_d = (match_q == MATCH_TOP) ? match_q : match_q + 4'd1;
            else
              match_d = 4'd0;
            locked_d = (match_d == MATCH_TOP);
          end else if (lcnt_q == CNT_MAX) begin
            to_evt = 1'b1;
          end else begin
            lcnt_d = lcnt_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (to_evt) begin
        timeout_d = 1'b1;
        locked_d  = 1'b0;
        match_d   = 4'd0;
        first_d   = 1'b1;
        state_d   = ST_SYNC;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      high_q    <= '0;
      low_q     <= '0;
      period_q  <= '0;
      prev_q    <= '0;
      match_q   <= 4'd0;
      first_q   <= 1'b1;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt_d;
      high_q    <= high_d;
      low_q     <= low_d;
      period_q  <= period_d;
      prev_q    <= prev_d;
      match_q   <= match_d;
      first_q   <= first_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign high_time  = high_q;
  assign low_time   = low_q;
  assign period     = period_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench for clk_ratio_meter: stimulus queues expected pulses,
// a negedge monitor pops and compares whenever meas_valid or timeout fires.
module tb_clk_ratio_meter;

  localparam int MAX_DIV = 255;
  localparam int LOCK_N  = 4;
  localparam int CW      = $clog2(MAX_DIV + 1);

  logic          clk_in = 1'b0;
  logic          rst_n, en, sig_in;
  logic [CW-1:0] high_time, low_time;
  logic [CW:0]   period;
  logic          meas_valid, locked, timeout;

  clk_ratio_meter #(.MAX_DIV(MAX_DIV), .LOCK_N(LOCK_N), .CNT_WIDTH(CW)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .sig_in     (sig_in),
    .high_time  (high_time),
    .low_time   (low_time),
    .period     (period),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit is_to;
    int h;
    int l;
    int p;
    bit lk;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_evt = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && (meas_valid === 1'b1 || timeout === 1'b1)) begin
      chk("pulse_exclusive", int'(meas_valid & timeout), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0b timeout=%0b expected none (cycle %0d)",
                 meas_valid, timeout, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind_timeout", int'(timeout), int'(e.is_to));
        if (!e.is_to) begin
          chk("high_time", int'(high_time), e.h);
          chk("low_time", int'(low_time), e.l);
          chk("period", int'(period), e.p);
        end
        chk("locked_at_pulse", int'(locked), int'(e.lk));
        if (e.gap != 0) chk("pulse_gap", cyc - last_evt, e.gap);
      end
      last_evt = cyc;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Queue the measurement this period will produce, then drive it.
  task automatic per(input int h, input int l, input bit lk, input int gap);
    exp_t e;
    e.is_to = 1'b0; e.h = h; e.l = l; e.p = h + l; e.lk = lk; e.gap = gap;
    sb.push_back(e);
    sig_in = 1'b1;
    cycles(h);
    sig_in = 1'b0;
    cycles(l);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_high_time"}, int'(high_time), 0);
    chk({tag, "_low_time"}, int'(low_time), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    exp_t t;
    rst_n = 1'b0; en = 1'b0; sig_in = 1'b0;
    cycles(10);
    chk_all_zero("reset");

    rst_n = 1'b1; en = 1'b1;
    cycles(300);
    chk_all_zero("sync_wait");

    for (int i = 0; i < 6; i++) per(2, 3, i >= 3, (i == 0) ? 0 : 5);
    for (int i = 0; i < 4; i++) per(4, 4, i == 3, 8);

    // Stuck high: the rise completes the last 4/4 period, then timeout.
    t.is_to = 1'b1; t.h = 0; t.l = 0; t.p = 0; t.lk = 1'b0; t.gap = MAX_DIV;
    sb.push_back(t);
    sig_in = 1'b1;
    cycles(300);
    sig_in = 1'b0;
    cycles(20);

    for (int i = 0; i < 5; i++) per(3, 2, i >= 3, (i == 0) ? 0 : 5);

    // Drop enable mid-LOW while locked.
    sig_in = 1'b1;
    cycles(3);
    sig_in = 1'b0;
    cycles(10);
    chk("pre_drop_locked", int'(locked), 1);
    en = 1'b0;
    cycles(1);
    chk("drop_locked", int'(locked), 0);
    chk("drop_meas_valid", int'(meas_valid), 0);
    chk("drop_high_hold", int'(high_time), 3);
    chk("drop_low_hold", int'(low_time), 2);
    chk("drop_period_hold", int'(period), 5);
    cycles(5);
    en = 1'b1;
    cycles(10);

    per(4, 5, 1'b0, 0);
    for (int i = 0; i < 4; i++) per(1, 1, i == 3, 2);
    per(255, 255, 1'b0, 510);

    // Reset while the FSM sits in HIGH.
    sig_in = 1'b1;
    cycles(8);
    chk("pre_reset_period", int'(period), 510);
    rst_n = 1'b0;
    cycles(1);
    chk_all_zero("mid_reset");
    cycles(5);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
